// File: rtl/pcs_defs.sv
// Shared 1000BASE-X PCS definitions: control-code bytes, idle data bytes and
// the transmit state encoding. The Receive block uses the same constants.
package pcs_defs;

    // Special code groups, as 8-bit values fed to the 8b/10b encoder with is_k=1
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;

    // Second group of the idle ordered sets: D5.6 for /I1/, D16.2 for /I2/
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    // Group emitted while reset is held: K28.5 taken from RD-
    localparam logic [9:0] RESET_CODE = 10'b0011111010;

    // Transmit ordered-set state encoding
    localparam logic [2:0] ST_IDLE_1  = 3'd0;
    localparam logic [2:0] ST_IDLE_2  = 3'd1;
    localparam logic [2:0] ST_SOP     = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_EOP_T   = 3'd4;
    localparam logic [2:0] ST_EOP_R   = 3'd5;
    localparam logic [2:0] ST_EOP_R2  = 3'd6;

endpackage

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder. The 6b sub-block is chosen from rd_in, the
// 4b sub-block from the disparity left by the 6b sub-block. Output bit 9 is 'a'.
module encoder_8b10b (
    input  logic [7:0] data,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x_val;
    logic [2:0] y_val;
    logic [5:0] six_n;
    logic [5:0] six_p;
    logic [5:0] six;
    logic       rd_mid;
    logic [3:0] four_n;
    logic [3:0] four_p;
    logic [3:0] four;
    logic       use_a7;

    assign x_val = data[4:0];
    assign y_val = data[7:5];

    // 5b/6b table (RD- form, RD+ form) and disparity after the 6b sub-block
    always_comb begin
        {six_n, six_p} = {6'b100111, 6'b011000};
        case (x_val)
            5'd0:  {six_n, six_p} = {6'b100111, 6'b011000};
            5'd1:  {six_n, six_p} = {6'b011101, 6'b100010};
            5'd2:  {six_n, six_p} = {6'b101101, 6'b010010};
            5'd3:  {six_n, six_p} = {6'b110001, 6'b110001};
            5'd4:  {six_n, six_p} = {6'b110101, 6'b001010};
            5'd5:  {six_n, six_p} = {6'b101001, 6'b101001};
            5'd6:  {six_n, six_p} = {6'b011001, 6'b011001};
            5'd7:  {six_n, six_p} = {6'b111000, 6'b000111};
            5'd8:  {six_n, six_p} = {6'b111001, 6'b000110};
            5'd9:  {six_n, six_p} = {6'b100101, 6'b100101};
            5'd10: {six_n, six_p} = {6'b010101, 6'b010101};
            5'd11: {six_n, six_p} = {6'b110100, 6'b110100};
            5'd12: {six_n, six_p} = {6'b001101, 6'b001101};
            5'd13: {six_n, six_p} = {6'b101100, 6'b101100};
            5'd14: {six_n, six_p} = {6'b011100, 6'b011100};
            5'd15: {six_n, six_p} = {6'b010111, 6'b101000};
            5'd16: {six_n, six_p} = {6'b011011, 6'b100100};
            5'd17: {six_n, six_p} = {6'b100011, 6'b100011};
            5'd18: {six_n, six_p} = {6'b010011, 6'b010011};
            5'd19: {six_n, six_p} = {6'b110010, 6'b110010};
            5'd20: {six_n, six_p} = {6'b001011, 6'b001011};
            5'd21: {six_n, six_p} = {6'b101010, 6'b101010};
            5'd22: {six_n, six_p} = {6'b011010, 6'b011010};
            5'd23: {six_n, six_p} = {6'b111010, 6'b000101};
            5'd24: {six_n, six_p} = {6'b110011, 6'b001100};
            5'd25: {six_n, six_p} = {6'b100110, 6'b100110};
            5'd26: {six_n, six_p} = {6'b010110, 6'b010110};
            5'd27: {six_n, six_p} = {6'b110110, 6'b001001};
            5'd28: {six_n, six_p} = is_k ? {6'b001111, 6'b110000} : {6'b001110, 6'b001110};
            5'd29: {six_n, six_p} = {6'b101110, 6'b010001};
            5'd30: {six_n, six_p} = {6'b011110, 6'b100001};
            5'd31: {six_n, six_p} = {6'b101011, 6'b010100};
            default: {six_n, six_p} = {6'b100111, 6'b011000};
        endcase
        six    = rd_in ? six_p : six_n;
        rd_mid = rd_in ^ ($countones(six) != 3);
    end

    // 3b/4b table; D.x.7 takes the alternate form where P7 would create a run of five
    always_comb begin
        use_a7 = (!rd_mid && (x_val == 5'd17 || x_val == 5'd18 || x_val == 5'd20)) ||
                 ( rd_mid && (x_val == 5'd11 || x_val == 5'd13 || x_val == 5'd14));
        {four_n, four_p} = {4'b1011, 4'b0100};
        if (is_k) begin
            case (y_val)
                3'd0: {four_n, four_p} = {4'b1011, 4'b0100};
                3'd1: {four_n, four_p} = {4'b0110, 4'b1001};
                3'd2: {four_n, four_p} = {4'b1010, 4'b0101};
                3'd3: {four_n, four_p} = {4'b1100, 4'b0011};
                3'd4: {four_n, four_p} = {4'b1101, 4'b0010};
                3'd5: {four_n, four_p} = {4'b0101, 4'b1010};
                3'd6: {four_n, four_p} = {4'b1001, 4'b0110};
                default: {four_n, four_p} = {4'b0111, 4'b1000};
            endcase
        end else begin
            case (y_val)
                3'd0: {four_n, four_p} = {4'b1011, 4'b0100};
                3'd1: {four_n, four_p} = {4'b1001, 4'b1001};
                3'd2: {four_n, four_p} = {4'b0101, 4'b0101};
                3'd3: {four_n, four_p} = {4'b1100, 4'b0011};
                3'd4: {four_n, four_p} = {4'b1101, 4'b0010};
                3'd5: {four_n, four_p} = {4'b1010, 4'b1010};
                3'd6: {four_n, four_p} = {4'b0110, 4'b0110};
                default: {four_n, four_p} = use_a7 ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
            endcase
        end
        four   = rd_mid ? four_p : four_n;
        rd_out = rd_mid ^ ($countones(four) != 2);
        code   = {six, four};
    end

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: turns the GMII byte stream into 10-bit code groups,
// framing packets with /S/ and /T/R/(R/), filling gaps with /I1/ or /I2/ idles.
module pcs_transmit
    import pcs_defs::*;
(
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       tx_rd
);

    logic [2:0] state_q, state_d;
    logic [9:0] tx_code_group_q, tx_code_group_d;
    logic       tx_rd_q, tx_rd_d;
    logic       tx_even_q, tx_even_d;
    logic [7:0] enc_data;
    logic       enc_is_k;
    logic [9:0] enc_code;
    logic       enc_rd_out;

    encoder_8b10b u_encoder (
        .data   (enc_data),
        .is_k   (enc_is_k),
        .rd_in  (tx_rd_q),
        .code   (enc_code),
        .rd_out (enc_rd_out)
    );

    // Pick the symbol for this slot and the next ordered-set state
    always_comb begin
        state_d   = state_q;
        enc_data  = K28_5;
        enc_is_k  = 1'b1;
        tx_even_d = ~tx_even_q;
        case (state_q)
            ST_IDLE_1: begin
                if (TX_EN) begin
                    enc_data = K27_7;
                    state_d  = ST_DATA;
                end else begin
                    enc_data = K28_5;
                    state_d  = ST_IDLE_2;
                end
            end
            ST_IDLE_2: begin
                // D16.2 from RD+ and D5.6 from RD- both leave RD negative
                enc_is_k = 1'b0;
                enc_data = tx_rd_q ? D16_2 : D5_6;
                state_d  = TX_EN ? ST_SOP : ST_IDLE_1;
            end
            ST_SOP: begin
                enc_data = K27_7;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                if (!TX_EN) begin
                    enc_data = K29_7;
                    state_d  = ST_EOP_R;
                end else if (TX_ER) begin
                    enc_data = K30_7;
                end else begin
                    enc_data = TXD;
                    enc_is_k = 1'b0;
                end
            end
            ST_EOP_T: begin
                enc_data = K29_7;
                state_d  = ST_EOP_R;
            end
            ST_EOP_R: begin
                // A second /R/ is added when needed so idles begin on an even slot
                enc_data = K23_7;
                state_d  = tx_even_d ? ST_IDLE_1 : ST_EOP_R2;
            end
            ST_EOP_R2: begin
                enc_data = K23_7;
                state_d  = ST_IDLE_1;
            end
            default: begin
                enc_data = K28_5;
                state_d  = ST_IDLE_1;
            end
        endcase
        tx_code_group_d = enc_code;
        tx_rd_d         = enc_rd_out;
    end

    // Register the emitted group, its resulting disparity, slot parity and state
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q         <= ST_IDLE_2;
            tx_code_group_q <= RESET_CODE;
            tx_rd_q         <= 1'b1;
            tx_even_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tx_code_group_q <= tx_code_group_d;
            tx_rd_q         <= tx_rd_d;
            tx_even_q       <= tx_even_d;
        end
    end

    assign tx_code_group = tx_code_group_q;
    assign tx_rd         = tx_rd_q;
    assign tx_even       = tx_even_q;

endmodule

// File: tb/tb_pcs_transmit.sv
// Self-checking bench for pcs_transmit: directed framing cases followed by a
// randomized byte stream compared against a behavioural model of the PCS.
module tb_pcs_transmit;

    logic       clk;
    logic       RESET;
    logic [7:0] TXD;
    logic       TX_EN;
    logic       TX_ER;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       tx_rd;

    int tests;
    int fails;

    localparam int M_IDLE  = 0;
    localparam int M_SOP   = 1;
    localparam int M_FRAME = 2;
    localparam int M_TAIL  = 3;

    int         mdl_mode;
    logic       mdl_even;
    logic       mdl_rd;
    logic [9:0] exp_code;

    logic [5:0] six_neg [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [3:0] dfour_neg [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] kfour_neg [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};

    pcs_transmit dut (
        .clk           (clk),
        .RESET         (RESET),
        .TXD           (TXD),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .tx_code_group (tx_code_group),
        .tx_even       (tx_even),
        .tx_rd         (tx_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: RD- forms from the tables, the RD+ form is the complement
    // wherever a symbol has two forms; disparity flips on unbalanced sub-blocks.
    function automatic logic [10:0] modelEncode(input logic [7:0] b, input logic k, input logic rd);
        logic [5:0] s;
        logic [3:0] f;
        logic       r;
        int         x;
        int         y;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        r = rd;
        s = (k && x == 28) ? 6'b001111 : six_neg[x];
        if (r && ($countones(s) != 3 || s == 6'b111000)) s = ~s;
        if ($countones(s) != 3) r = ~r;
        if (k) begin
            f = kfour_neg[y];
            if (r) f = ~f;
        end else begin
            f = dfour_neg[y];
            if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14))))
                f = 4'b0111;
            if (r && ($countones(f) != 2 || f == 4'b1100)) f = ~f;
        end
        if ($countones(f) != 2) r = ~r;
        return {r, s, f};
    endfunction

    task automatic modelReset();
        mdl_mode = M_IDLE;
        mdl_even = 1'b0;
        mdl_rd   = 1'b1;
        exp_code = 10'b0011111010;
    endtask

    // One byte time of the model: decide the symbol, then encode it
    task automatic modelStep(input logic en, input logic er, input logic [7:0] d);
        logic [7:0]  sb;
        logic        sk;
        logic        cur_even;
        logic [10:0] res;
        cur_even = mdl_even;
        sb = 8'hBC;
        sk = 1'b1;
        case (mdl_mode)
            M_FRAME: begin
                if (en) begin
                    if (er) sb = 8'hFE;
                    else begin sb = d; sk = 1'b0; end
                end else begin
                    sb = 8'hFD;
                    mdl_mode = M_TAIL;
                end
            end
            M_TAIL: begin
                sb = 8'hF7;
                if (!cur_even) mdl_mode = M_IDLE;
            end
            M_SOP: begin
                sb = 8'hFB;
                mdl_mode = M_FRAME;
            end
            default: begin
                if (cur_even) begin
                    if (en) begin sb = 8'hFB; mdl_mode = M_FRAME; end
                    else sb = 8'hBC;
                end else begin
                    sb = mdl_rd ? 8'h50 : 8'hC5;
                    sk = 1'b0;
                    mdl_mode = en ? M_SOP : M_IDLE;
                end
            end
        endcase
        res      = modelEncode(sb, sk, mdl_rd);
        mdl_rd   = res[10];
        exp_code = res[9:0];
        mdl_even = ~cur_even;
    endtask

    task automatic checkOutput(input string tag);
        tests++;
        assert (tx_code_group === exp_code) else begin
            fails++;
            $error("[TB] FAIL %s code: got %b expected %b", tag, tx_code_group, exp_code);
        end
        tests++;
        assert (tx_rd === mdl_rd) else begin
            fails++;
            $error("[TB] FAIL %s rd: got %b expected %b", tag, tx_rd, mdl_rd);
        end
        tests++;
        assert (tx_even === mdl_even) else begin
            fails++;
            $error("[TB] FAIL %s even: got %b expected %b", tag, tx_even, mdl_even);
        end
    endtask

    task automatic checkCode(input string tag, input logic [9:0] expected);
        tests++;
        assert (tx_code_group === expected) else begin
            fails++;
            $error("[TB] FAIL %s: got %b expected %b", tag, tx_code_group, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Drive one byte, let one edge pass, then compare against the model
    task automatic applyStimulus(input logic en, input logic er, input logic [7:0] d, input string tag);
        TX_EN = en;
        TX_ER = er;
        TXD   = d;
        @(posedge clk);
        #1;
        modelStep(en, er, d);
        checkOutput(tag);
    endtask

    logic en_r;

    initial begin
        tests = 0;
        fails = 0;
        RESET = 1'b1;
        TX_EN = 1'b0;
        TX_ER = 1'b0;
        TXD   = 8'h00;
        modelReset();
        #2;
        checkOutput("reset");
        checkCode("reset_k28_5", 10'b0011111010);
        checkBit("reset_rd", tx_rd, 1'b1);
        checkBit("reset_even", tx_even, 1'b0);
        #10 RESET = 1'b0;

        // Idle stream after reset: /I2/ pairs
        applyStimulus(1'b0, 1'b0, 8'h00, "idle0");
        checkCode("first_d16_2", 10'b1001000101);
        checkBit("first_rd", tx_rd, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, "idle1");
        checkCode("idle_k28_5", 10'b0011111010);
        checkBit("idle_rd", tx_rd, 1'b1);
        for (int i = 2; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'h00, "idle");
        checkBit("idle1_even", tx_even, 1'b1);

        // Frame starting in IDLE_1, /T/ on an odd slot -> /T/R/R/
        applyStimulus(1'b1, 1'b0, 8'h55, "sop_even");
        checkCode("s_idle1", 10'b1101101000);
        applyStimulus(1'b1, 1'b0, 8'h55, "d21_2");
        checkCode("d21_2", 10'b1010100101);
        applyStimulus(1'b1, 1'b0, 8'h00, "d0_0");
        checkCode("d0_0", 10'b1001110100);
        applyStimulus(1'b0, 1'b0, 8'h00, "t_odd");
        checkCode("t_odd", 10'b1011101000);
        applyStimulus(1'b0, 1'b0, 8'h00, "r1");
        checkCode("r1", 10'b1110101000);
        applyStimulus(1'b0, 1'b0, 8'h00, "r2");
        checkCode("r2", 10'b1110101000);
        applyStimulus(1'b0, 1'b0, 8'h00, "k_after_rr");
        checkCode("k_after_rr", 10'b0011111010);
        checkBit("k_after_rr_even", tx_even, 1'b0);

        // Frame starting in IDLE_2 (first byte dropped), /V/ mid-frame, /T/ even
        applyStimulus(1'b1, 1'b0, 8'hAA, "preamble_drop");
        checkCode("preamble_drop", 10'b1001000101);
        applyStimulus(1'b1, 1'b0, 8'hBB, "sop_odd_start");
        checkCode("s_sop", 10'b1101101000);
        applyStimulus(1'b1, 1'b0, 8'hB5, "d21_5a");
        checkCode("d21_5a", 10'b1010101010);
        applyStimulus(1'b1, 1'b1, 8'hB5, "err");
        checkCode("v_rdneg", 10'b0111101000);
        applyStimulus(1'b1, 1'b0, 8'hB5, "d21_5b");
        checkCode("d21_5b", 10'b1010101010);
        applyStimulus(1'b0, 1'b0, 8'h00, "t_even");
        checkCode("t_even", 10'b1011101000);
        applyStimulus(1'b0, 1'b1, 8'h00, "r_single");
        checkCode("r_single", 10'b1110101000);
        applyStimulus(1'b0, 1'b1, 8'h00, "k_after_r");
        checkCode("k_after_r", 10'b0011111010);

        // Randomized byte stream with frames, errors and carrier extension
        en_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) en_r = ~en_r;
            applyStimulus(en_r, ($urandom_range(0, 15) == 0), 8'($urandom), "random");
        end

        // Reset asserted mid-frame takes effect without a clock edge
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, "pre_reset_idle");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), "pre_reset_frame");
        #2;
        RESET = 1'b1;
        TX_EN = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        checkCode("async_reset_code", 10'b0011111010);
        #2 RESET = 1'b0;

        // Clean frame after reset
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, "post_reset_idle");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), "post_reset_frame");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, "post_reset_tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
